// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared op codes, func bit index and issue-state encoding
package arith_pkg;

  localparam logic [2:0] ARITH_OP_ADD  = 3'd0;
  localparam logic [2:0] ARITH_OP_SLT  = 3'd1;
  localparam logic [2:0] ARITH_OP_SLTU = 3'd2;
  localparam logic [2:0] ARITH_OP_AND  = 3'd3;
  localparam logic [2:0] ARITH_OP_OR   = 3'd4;
  localparam logic [2:0] ARITH_OP_XOR  = 3'd5;
  localparam logic [2:0] ARITH_OP_SLL  = 3'd6;
  localparam logic [2:0] ARITH_OP_SRL  = 3'd7;

  // func bit that selects subtract when op is ADD
  localparam int ARITH_FUNC_SUB = 0;

  typedef enum logic [1:0] {
    ISSUE_IDLE  = 2'd0,
    ISSUE_START = 2'd1,
    ISSUE_BUSY  = 2'd2,
    ISSUE_HOLD  = 2'd3
  } issue_state_e;

endpackage

// File: rtl/arith_issue.sv
// rtl/arith_issue.sv - issue/retire stage around arithmetic_unit with flush and watchdog
module arith_issue #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_flush,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [2:0]      i_op,
  input  logic [1:0]      i_func,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  input  logic [4:0]      i_rd,
  output logic            o_au_start,
  output logic [2:0]      o_au_op,
  output logic [1:0]      o_au_func,
  output logic [XLEN-1:0] o_au_op1,
  output logic [XLEN-1:0] o_au_op2,
  input  logic            i_au_valid,
  input  logic [XLEN-1:0] i_au_result,
  output logic            o_wb_valid,
  input  logic            i_wb_ready,
  output logic [4:0]      o_wb_rd,
  output logic [XLEN-1:0] o_wb_data,
  output logic            o_err
);
  import arith_pkg::*;

  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  issue_state_e    state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic [1:0]      func_q, func_d;
  logic [XLEN-1:0] op1_q, op1_d;
  logic [XLEN-1:0] op2_q, op2_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] data_q, data_d;
  logic            kill_q, kill_d;
  logic            err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            accept;

  // o_ready is forced low while reset is asserted
  assign o_ready = ~i_rst & ((state_q == ISSUE_IDLE) |
                             ((state_q == ISSUE_HOLD) & i_wb_ready));
  assign accept  = i_valid & o_ready & ~i_flush;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    func_d  = func_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    rd_d    = rd_q;
    data_d  = data_q;
    kill_d  = kill_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      ISSUE_IDLE: begin
        if (accept) begin
          op_d    = i_op;
          func_d  = i_func;
          op1_d   = i_rs1;
          op2_d   = i_rs2;
          rd_d    = i_rd;
          kill_d  = 1'b0;
          state_d = ISSUE_START;
        end
      end
      ISSUE_START: begin
        // the unit cannot be aborted, so a flush here only marks the op as dead
        cnt_d   = '0;
        kill_d  = kill_q | i_flush;
        state_d = ISSUE_BUSY;
      end
      ISSUE_BUSY: begin
        if (i_au_valid) begin
          if (kill_q | i_flush) begin
            state_d = ISSUE_IDLE;
          end else begin
            data_d  = i_au_result;
            state_d = (rd_q != 5'd0) ? ISSUE_HOLD : ISSUE_IDLE;
          end
        end else begin
          kill_d = kill_q | i_flush;
          if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            err_d   = 1'b1;
            state_d = ISSUE_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ISSUE_HOLD: begin
        if (i_flush) begin
          state_d = ISSUE_IDLE;
        end else if (i_wb_ready) begin
          if (accept) begin
            op_d    = i_op;
            func_d  = i_func;
            op1_d   = i_rs1;
            op2_d   = i_rs2;
            rd_d    = i_rd;
            kill_d  = 1'b0;
            state_d = ISSUE_START;
          end else begin
            state_d = ISSUE_IDLE;
          end
        end
      end
      default: state_d = ISSUE_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ISSUE_IDLE;
      op_q    <= '0;
      func_q  <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      rd_q    <= '0;
      data_q  <= '0;
      kill_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      func_q  <= func_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
      kill_q  <= kill_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_au_start = (state_q == ISSUE_START);
  assign o_au_op    = op_q;
  assign o_au_func  = func_q;
  assign o_au_op1   = op1_q;
  assign o_au_op2   = op2_q;
  assign o_wb_valid = (state_q == ISSUE_HOLD);
  assign o_wb_rd    = rd_q;
  assign o_wb_data  = data_q;
  assign o_err      = err_q;

endmodule

// File: tb/tb_arith_issue.sv
// tb/tb_arith_issue.sv - directed self-checking bench for arith_issue
module tb_arith_issue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        valid = 1'b0;
  logic        ready;
  logic [2:0]  op = 3'd0;
  logic [1:0]  func = 2'd0;
  logic [31:0] rs1 = 32'd0;
  logic [31:0] rs2 = 32'd0;
  logic [4:0]  rd = 5'd0;
  logic        au_start;
  logic [2:0]  au_op;
  logic [1:0]  au_func;
  logic [31:0] au_op1;
  logic [31:0] au_op2;
  logic        au_valid = 1'b0;
  logic [31:0] au_result = 32'd0;
  logic        wb_valid;
  logic        wb_ready = 1'b0;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        err;

  int vectors = 0;
  int misses  = 0;

  arith_issue #(.XLEN(32), .TIMEOUT(16)) dut (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_valid(valid), .o_ready(ready),
    .i_op(op), .i_func(func), .i_rs1(rs1), .i_rs2(rs2), .i_rd(rd),
    .o_au_start(au_start), .o_au_op(au_op), .o_au_func(au_func),
    .o_au_op1(au_op1), .o_au_op2(au_op2),
    .i_au_valid(au_valid), .i_au_result(au_result),
    .o_wb_valid(wb_valid), .i_wb_ready(wb_ready), .o_wb_rd(wb_rd),
    .o_wb_data(wb_data), .o_err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      misses++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] d);
    valid = 1'b1;
    op    = 3'd0;
    func  = f;
    rs1   = a;
    rs2   = b;
    rd    = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "bench time limit");
  end

  initial begin
    // reset state
    tick();
    tick();
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_start", 32'(au_start), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_op1", au_op1, 32'd0);
    rst = 1'b0;
    #1;
    chk("idle_ready", 32'(ready), 32'd1);

    // ADD 5,7 rd=3, unit latency 1
    wb_ready = 1'b1;
    issue(2'b00, 32'd5, 32'd7, 5'd3);
    #1;
    chk("add_ready", 32'(ready), 32'd1);
    tick();
    valid = 1'b0;
    chk("add_start", 32'(au_start), 32'd1);
    chk("add_op1", au_op1, 32'd5);
    chk("add_op2", au_op2, 32'd7);
    chk("add_op", 32'(au_op), 32'd0);
    chk("add_busy_ready", 32'(ready), 32'd0);
    tick();
    chk("add_start_pulse", 32'(au_start), 32'd0);
    au_valid = 1'b1;
    au_result = 32'd12;
    tick();
    au_valid = 1'b0;
    chk("add_wb_valid", 32'(wb_valid), 32'd1);
    chk("add_wb_rd", 32'(wb_rd), 32'd3);
    chk("add_wb_data", wb_data, 32'd12);
    tick();
    chk("add_wb_done", 32'(wb_valid), 32'd0);
    chk("add_idle_ready", 32'(ready), 32'd1);

    // SUB 5,7 rd=4 with writeback stalled 4 cycles
    wb_ready = 1'b0;
    issue(2'b01, 32'd5, 32'd7, 5'd4);
    tick();
    valid = 1'b0;
    chk("sub_start", 32'(au_start), 32'd1);
    chk("sub_func", 32'(au_func), 32'd1);
    tick();
    au_valid = 1'b1;
    au_result = 32'hFFFF_FFFE;
    tick();
    au_valid = 1'b0;
    chk("sub_wb_valid", 32'(wb_valid), 32'd1);
    chk("sub_wb_data", wb_data, 32'hFFFF_FFFE);
    chk("sub_hold_ready", 32'(ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("sub_hold_valid", 32'(wb_valid), 32'd1);
      chk("sub_hold_data", wb_data, 32'hFFFF_FFFE);
      chk("sub_hold_rd", 32'(wb_rd), 32'd4);
      chk("sub_hold_ready", 32'(ready), 32'd0);
    end
    // handshake and back-to-back accept of ADD 1,1 rd=0
    wb_ready = 1'b1;
    issue(2'b00, 32'd1, 32'd1, 5'd0);
    #1;
    chk("b2b_ready", 32'(ready), 32'd1);
    tick();
    valid = 1'b0;
    chk("b2b_start", 32'(au_start), 32'd1);
    chk("b2b_wb_valid", 32'(wb_valid), 32'd0);
    chk("b2b_op1", au_op1, 32'd1);

    // rd=0 drops result
    tick();
    au_valid = 1'b1;
    au_result = 32'd2;
    tick();
    au_valid = 1'b0;
    chk("rd0_wb_valid", 32'(wb_valid), 32'd0);
    chk("rd0_ready", 32'(ready), 32'd1);

    // flush in BUSY then result
    issue(2'b00, 32'd3, 32'd4, 5'd5);
    tick();
    valid = 1'b0;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flbusy_ready", 32'(ready), 32'd0);
    chk("flbusy_wb_valid", 32'(wb_valid), 32'd0);
    au_valid = 1'b1;
    au_result = 32'h55;
    tick();
    au_valid = 1'b0;
    chk("flbusy_no_wb", 32'(wb_valid), 32'd0);
    chk("flbusy_idle", 32'(ready), 32'd1);
    tick();
    chk("flbusy_no_wb2", 32'(wb_valid), 32'd0);

    // flush with valid in IDLE
    issue(2'b00, 32'd8, 32'd8, 5'd2);
    flush = 1'b1;
    tick();
    valid = 1'b0;
    flush = 1'b0;
    chk("flidle_no_start", 32'(au_start), 32'd0);
    tick();
    chk("flidle_no_start2", 32'(au_start), 32'd0);
    chk("flidle_ready", 32'(ready), 32'd1);

    // flush during START
    issue(2'b00, 32'd6, 32'd6, 5'd2);
    tick();
    valid = 1'b0;
    chk("flstart_start", 32'(au_start), 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    au_valid = 1'b1;
    au_result = 32'h66;
    tick();
    au_valid = 1'b0;
    chk("flstart_no_wb", 32'(wb_valid), 32'd0);
    chk("flstart_idle", 32'(ready), 32'd1);

    // flush in HOLD
    wb_ready = 1'b0;
    issue(2'b00, 32'd7, 32'd7, 5'd9);
    tick();
    valid = 1'b0;
    tick();
    au_valid = 1'b1;
    au_result = 32'h77;
    tick();
    au_valid = 1'b0;
    chk("flhold_wb_valid", 32'(wb_valid), 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flhold_dropped", 32'(wb_valid), 32'd0);
    chk("flhold_ready", 32'(ready), 32'd1);

    // watchdog: unit never answers
    wb_ready = 1'b1;
    issue(2'b00, 32'd9, 32'd9, 5'd6);
    tick();
    valid = 1'b0;
    tick();
    repeat (15) tick();
    chk("wd_err_pending", 32'(err), 32'd0);
    chk("wd_busy_ready", 32'(ready), 32'd0);
    tick();
    chk("wd_err", 32'(err), 32'd1);
    chk("wd_idle_ready", 32'(ready), 32'd1);
    issue(2'b00, 32'd2, 32'd3, 5'd7);
    tick();
    valid = 1'b0;
    chk("wd_next_start", 32'(au_start), 32'd1);
    tick();
    au_valid = 1'b1;
    au_result = 32'd5;
    tick();
    au_valid = 1'b0;
    chk("wd_next_wb_valid", 32'(wb_valid), 32'd1);
    chk("wd_next_wb_data", wb_data, 32'd5);
    chk("wd_next_wb_rd", 32'(wb_rd), 32'd7);
    chk("wd_err_sticky", 32'(err), 32'd1);
    tick();
    chk("wd_err_sticky2", 32'(err), 32'd1);

    // reset while BUSY, then spurious result pulse
    issue(2'b00, 32'hA, 32'hB, 5'd8);
    tick();
    valid = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk("mrst_ready", 32'(ready), 32'd0);
    chk("mrst_err", 32'(err), 32'd0);
    chk("mrst_wb_valid", 32'(wb_valid), 32'd0);
    chk("mrst_start", 32'(au_start), 32'd0);
    chk("mrst_op1", au_op1, 32'd0);
    chk("mrst_wb_data", wb_data, 32'd0);
    chk("mrst_wb_rd", 32'(wb_rd), 32'd0);
    tick();
    rst = 1'b0;
    au_valid = 1'b1;
    au_result = 32'h99;
    tick();
    au_valid = 1'b0;
    chk("spur_wb_valid", 32'(wb_valid), 32'd0);
    chk("spur_ready", 32'(ready), 32'd1);
    chk("spur_start", 32'(au_start), 32'd0);
    tick();
    chk("spur_wb_valid2", 32'(wb_valid), 32'd0);
    chk("spur_wb_data", wb_data, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

endmodule
